// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 per-channel max pooling over the conv block's channel-interleaved beat stream.
// Define CONV_MAXPOOL_RELU_EN to clamp negative pooled words to zero before the output register.
module conv_maxpool2x2 #(
    parameter int unsigned IN_HEIGHT  = 4,
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                        i_aclk,
    input  logic                        i_areset,
    input  logic                        i_tvalid,
    output logic                        o_tready,
    input  logic [LANES*WORD_WIDTH-1:0] i_tdata,
    input  logic                        i_tready,
    output logic                        o_tvalid,
    output logic [LANES*WORD_WIDTH-1:0] o_tdata,
    output logic                        o_tlast
);

    localparam int unsigned BPP    = CHANNELS / LANES;
    localparam int unsigned DATA_W = LANES * WORD_WIDTH;
    localparam int unsigned DEPTH  = (IN_WIDTH / 2) * BPP;
    localparam int unsigned BEAT_W = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int unsigned COL_W  = $clog2(IN_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IN_HEIGHT);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [DATA_W-1:0] lane_max(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if ($signed(a[k*WORD_WIDTH +: WORD_WIDTH]) > $signed(b[k*WORD_WIDTH +: WORD_WIDTH]))
                m[k*WORD_WIDTH +: WORD_WIDTH] = a[k*WORD_WIDTH +: WORD_WIDTH];
            else
                m[k*WORD_WIDTH +: WORD_WIDTH] = b[k*WORD_WIDTH +: WORD_WIDTH];
        end
        return m;
    endfunction

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d;

    logic              accept;
    logic              last_beat, last_col, last_row;
    logic              first_touch, pool_out;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] buf_rd, merged, pooled;
    logic [DATA_W-1:0] line_buf [DEPTH];

    assign o_tready = !tvalid_q || i_tready;
    assign accept   = i_tvalid && o_tready;

    assign last_beat = (beat_q == BEAT_W'(BPP - 1));
    assign last_col  = (col_q == COL_W'(IN_WIDTH - 1));
    assign last_row  = (row_q == ROW_W'(IN_HEIGHT - 1));

    // Even row + even column opens a pooling window; odd/odd closes it.
    assign first_touch = !row_q[0] && !col_q[0];
    assign pool_out    = row_q[0] && col_q[0];

    assign idx    = IDX_W'((32'(col_q) >> 1) * BPP + 32'(beat_q));
    assign buf_rd = line_buf[idx];
    assign merged = lane_max(buf_rd, i_tdata);

`ifdef CONV_MAXPOOL_RELU_EN
    always_comb begin
        pooled = merged;
        for (int k = 0; k < int'(LANES); k++) begin
            if (merged[k*WORD_WIDTH + WORD_WIDTH - 1]) pooled[k*WORD_WIDTH +: WORD_WIDTH] = '0;
        end
    end
`else
    assign pooled = merged;
`endif

    always_comb begin
        beat_d = beat_q;
        col_d  = col_q;
        row_d  = row_q;
        if (accept) begin
            if (last_beat) begin
                beat_d = '0;
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (tvalid_q && i_tready) tvalid_d = 1'b0;
        // A fresh load overrides the drain in the same edge, so no bubble is inserted.
        if (accept && pool_out) begin
            tvalid_d = 1'b1;
            tdata_d  = pooled;
            tlast_d  = last_row && last_col && last_beat;
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            beat_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            col_q    <= col_d;
            row_q    <= row_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    // No reset on the line: the first touch of each window overwrites stale contents.
    always_ff @(posedge i_aclk) begin
        if (accept && !pool_out) begin
            line_buf[idx] <= first_touch ? i_tdata : merged;
        end
    end

    assign o_tvalid = tvalid_q;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Bench for conv_maxpool2x2: directed and random frames checked against a window-max model.
// Honours CONV_MAXPOOL_RELU_EN when computing expected pooled words.
module tb_conv_maxpool2x2;

    localparam int H   = 4;
    localparam int W   = 4;
    localparam int CH  = 8;
    localparam int L   = 4;
    localparam int WW  = 8;
    localparam int BPP = CH / L;
    localparam int DW  = L * WW;

    logic          r_aclk = 1'b0;
    logic          i_areset;
    logic          i_tvalid;
    logic          o_tready;
    logic [DW-1:0] i_tdata;
    logic          i_tready;
    logic          o_tvalid;
    logic [DW-1:0] o_tdata;
    logic          o_tlast;

    int errors = 0;
    int checks = 0;

    int            pix [H][W][CH];
    logic [DW-1:0] in_q [$];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   out_q [$];

    int            ready_mode  = 0;
    int            ready_phase = 0;
    int            tready_viol = 0;
    int            hold_viol   = 0;
    logic          prev_stall  = 1'b0;
    logic [DW:0]   prev_out    = '0;

    always #5 r_aclk = ~r_aclk;

    conv_maxpool2x2 dut (
        .i_aclk   (r_aclk),
        .i_areset (i_areset),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .i_tdata  (i_tdata),
        .i_tready (i_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast)
    );

    // Inputs change 1 time unit after posedge, so negedge sees what the next edge will use.
    always @(negedge r_aclk) begin
        if (!i_areset) begin
            if (o_tvalid && i_tready) out_q.push_back({o_tlast, o_tdata});
            if (o_tready !== (!o_tvalid || i_tready)) tready_viol <= tready_viol + 1;
            if (prev_stall && (o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== prev_out))
                hold_viol <= hold_viol + 1;
            prev_stall <= o_tvalid && !i_tready;
            prev_out   <= {o_tlast, o_tdata};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        i_tready = 1'b1;
        forever begin
            @(posedge r_aclk);
            #1;
            case (ready_mode)
                1: begin
                    i_tready    = (ready_phase == 0) || (ready_phase == 3);
                    ready_phase = (ready_phase + 1) % 4;
                end
                2:       i_tready = 1'($urandom_range(0, 1));
                default: i_tready = 1'b1;
            endcase
        end
    end

    // Appends one frame of pix to the input stream and its pooled result to the expectation.
    task automatic build_streams();
        logic [DW-1:0] bw;
        logic [DW:0]   e;
        int            m, v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int b = 0; b < BPP; b++) begin
                    for (int k = 0; k < L; k++) begin
                        v = pix[r][c][b*L+k];
                        bw[k*WW +: WW] = v[WW-1:0];
                    end
                    in_q.push_back(bw);
                end
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++)
                for (int b = 0; b < BPP; b++) begin
                    e = '0;
                    for (int k = 0; k < L; k++) begin
                        m = -1000;
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++)
                                if (pix[2*pr+dr][2*pc+dc][b*L+k] > m)
                                    m = pix[2*pr+dr][2*pc+dc][b*L+k];
`ifdef CONV_MAXPOOL_RELU_EN
                        if (m < 0) m = 0;
`endif
                        e[k*WW +: WW] = m[WW-1:0];
                    end
                    e[DW] = (pr == H / 2 - 1) && (pc == W / 2 - 1) && (b == BPP - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < CH; ch++) pix[r][c][ch] = r * 4 + c;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < CH; ch++) pix[r][c][ch] = v;
    endtask

    task automatic clear_queues();
        in_q.delete();
        exp_q.delete();
        out_q.delete();
    endtask

    // Sends up to max_beats from in_q; valid is held until the beat is accepted.
    task automatic drive(input int max_beats, input int gap_pct);
        int   sent = 0;
        logic acc;
        @(posedge r_aclk);
        #1;
        while (in_q.size() > 0 && sent < max_beats) begin
            if (!i_tvalid) i_tvalid = ($urandom_range(0, 99) >= gap_pct);
            i_tdata = in_q[0];
            @(negedge r_aclk);
            acc = i_tvalid && o_tready;
            @(posedge r_aclk);
            #1;
            if (acc) begin
                in_q.delete(0);
                sent++;
                i_tvalid = 1'b0;
            end
        end
        i_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int cyc = 0;
        while (out_q.size() < n && cyc < 400) begin
            @(posedge r_aclk);
            cyc++;
        end
        repeat (6) @(posedge r_aclk);
        #1;
    endtask

    task automatic test_reset();
        i_areset = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        repeat (2) @(posedge r_aclk);
        #2;
        checks++;
        if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b want 0/0/0",
                     o_tvalid, o_tdata, o_tlast);
        end
        i_areset = 1'b0;
        @(negedge r_aclk);
        checks++;
        if (o_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b want 1", o_tready);
        end
    endtask

    task automatic test_ramp();
        int          vals [8] = '{5, 5, 7, 7, 13, 13, 15, 15};
        logic [7:0]  v8;
        logic [DW:0] e;
        clear_queues();
        fill_ramp();
        build_streams();
        drive(1000, 0);
        wait_out(8);
        checks++;
        if (out_q.size() != 8) begin
            errors++;
            $display("FAIL ramp_count: got %0d beats want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            v8 = vals[i][7:0];
            e  = {(i == 7), {L{v8}}};
            checks++;
            if (out_q[i] !== e) begin
                errors++;
                $display("FAIL ramp_beat%0d: got %h want %h", i, out_q[i], e);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] w;
        logic [7:0] want;
        clear_queues();
        fill_const(-128);
        pix[1][0][2] = -1;
        build_streams();
        drive(1000, 0);
        wait_out(8);
        checks++;
        if (out_q.size() != 8) begin
            errors++;
            $display("FAIL signed_count: got %0d beats want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++)
            for (int k = 0; k < L; k++) begin
                w = out_q[i][k*WW +: WW];
`ifdef CONV_MAXPOOL_RELU_EN
                want = 8'h00;
`else
                want = (i == 0 && k == 2) ? 8'hFF : 8'h80;
`endif
                checks++;
                if (w !== want) begin
                    errors++;
                    $display("FAIL signed_beat%0d_lane%0d: got %h want %h", i, k, w, want);
                end
            end
    endtask

    task automatic test_backpressure();
        clear_queues();
        fill_ramp();
        build_streams();
        tready_viol = 0;
        hold_viol   = 0;
        ready_phase = 0;
        ready_mode  = 1;
        drive(1000, 0);
        wait_out(8);
        ready_mode = 0;
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (tready_viol != 0) begin
            errors++;
            $display("FAIL bp_tready: got %0d violations want 0", tready_viol);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        fill_const(127);
        build_streams();
        drive(10, 0);
        i_areset = 1'b1;
        #2;
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid: got %b want 0", o_tvalid);
        end
        repeat (2) @(posedge r_aclk);
        #1;
        i_areset = 1'b0;
        clear_queues();
        fill_ramp();
        build_streams();
        drive(1000, 0);
        wait_out(8);
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_beat%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        fill_ramp();
        build_streams();
        build_streams();
        drive(1000, 0);
        wait_out(16);
        checks++;
        if (out_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats want 16", out_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_queues();
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    for (int ch = 0; ch < CH; ch++)
                        pix[r][c][ch] = int'($urandom_range(0, 255)) - 128;
            build_streams();
        end
        tready_viol = 0;
        hold_viol   = 0;
        ready_mode  = 2;
        drive(1000, 30);
        wait_out(exp_q.size());
        ready_mode = 0;
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d beats want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat%0d: got %h want %h", i, out_q[i], exp_q[i]);
            end
        end
        checks++;
        if (tready_viol != 0 || hold_viol != 0) begin
            errors++;
            $display("FAIL rand_protocol: got %0d/%0d violations want 0/0", tready_viol, hold_viol);
        end
    endtask

    task automatic test_relu();
        logic [DW-1:0] want;
        clear_queues();
        fill_const(-5);
        build_streams();
        drive(1000, 0);
        wait_out(8);
`ifdef CONV_MAXPOOL_RELU_EN
        want = '0;
`else
        want = {L{8'hFB}};
`endif
        checks++;
        if (out_q.size() != 8) begin
            errors++;
            $display("FAIL relu_count: got %0d beats want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i][DW-1:0] !== want) begin
                errors++;
                $display("FAIL relu_beat%0d: got %h want %h", i, out_q[i][DW-1:0], want);
            end
        end
    endtask

    initial begin
        i_areset = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        test_reset();
        test_ramp();
        test_signed();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
